// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: decodes the immediate field of a 32-bit instruction word,
// sign/zero-extends it to DATA_W bits and queues the result in a 2-entry
// skid FIFO with valid/ready handshakes on both sides.
// Optional feature macro: IMM_BRANCH_SHIFT_EN (B/CB results become byte offsets).
module imm_extend_pipe #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              ResetL,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       Instr,
  input  logic              Ctrl,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] BusImm,
  output logic [2:0]        ImmType,
  output logic [CNT_W-1:0]  UnkCount
);

  typedef enum logic [2:0] {
    IT_NONE = 3'd0,
    IT_B    = 3'd1,
    IT_CB   = 3'd2,
    IT_D    = 3'd3,
    IT_I    = 3'd4,
    IT_IW   = 3'd5
  } imm_type_e;

`ifdef IMM_BRANCH_SHIFT_EN
  localparam int BR_SH = 2;
`else
  localparam int BR_SH = 0;
`endif

  imm_type_e         dec_type;
  logic [63:0]       dec_imm64;
  logic [DATA_W-1:0] dec_imm;
  logic              is_b, is_cb, is_d, is_i, is_iw;
  logic              ext;

  // head holds the oldest entry and drives the outputs; skid is the second slot
  logic [DATA_W-1:0] head_imm, skid_imm;
  imm_type_e         head_type, skid_type;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  unk;
  logic              push, pop;

  assign is_b  = Instr[31:26] inside {6'h05, 6'h25};
  assign is_cb = Instr[31:24] inside {8'hB4, 8'hB5, 8'h54};
  assign is_d  = Instr[31:21] inside {11'h1C0, 11'h1C2, 11'h3C0, 11'h3C2, 11'h5C0,
                                      11'h5C4, 11'h640, 11'h642, 11'h7C0, 11'h7C2};
  assign is_i  = Instr[31:22] inside {10'h244, 10'h248, 10'h2C4, 10'h2C8,
                                      10'h344, 10'h348, 10'h3C4, 10'h3C8};
  // a 32-bit build cannot represent the upper two halfword positions
  assign is_iw = (Instr[31:23] inside {9'h1A5, 9'h1E5}) && !((DATA_W == 32) && Instr[22]);

  // Combinational decode; first matching class wins, extension bit gated by Ctrl
  always_comb begin
    dec_type  = IT_NONE;
    dec_imm64 = '0;
    ext       = 1'b0;
    if (is_b) begin
      ext       = ~Ctrl & Instr[25];
      dec_type  = IT_B;
      dec_imm64 = {{38{ext}}, Instr[25:0]} << BR_SH;
    end else if (is_cb) begin
      ext       = ~Ctrl & Instr[23];
      dec_type  = IT_CB;
      dec_imm64 = {{45{ext}}, Instr[23:5]} << BR_SH;
    end else if (is_d) begin
      ext       = ~Ctrl & Instr[20];
      dec_type  = IT_D;
      dec_imm64 = {{55{ext}}, Instr[20:12]};
    end else if (is_i) begin
      ext       = ~Ctrl & Instr[21];
      dec_type  = IT_I;
      dec_imm64 = {{52{ext}}, Instr[21:10]};
    end else if (is_iw) begin
      dec_type  = IT_IW;
      dec_imm64 = {48'b0, Instr[20:5]} << {Instr[22:21], 4'b0000};
    end
  end

  assign dec_imm  = dec_imm64[DATA_W-1:0];
  assign InReady  = (occ != 2'd2);
  assign OutValid = (occ != 2'd0);
  assign push     = InValid & InReady;
  assign pop      = OutValid & OutReady;
  assign BusImm   = head_imm;
  assign ImmType  = head_type;
  assign UnkCount = unk;

  // FIFO occupancy and entry storage; head keeps its last value when drained
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      occ       <= 2'd0;
      head_imm  <= '0;
      head_type <= IT_NONE;
      skid_imm  <= '0;
      skid_type <= IT_NONE;
    end else begin
      case (occ)
        2'd0: if (push) begin
          head_imm  <= dec_imm;
          head_type <= dec_type;
          occ       <= 2'd1;
        end
        2'd1: begin
          if (push && pop) begin
            head_imm  <= dec_imm;
            head_type <= dec_type;
          end else if (push) begin
            skid_imm  <= dec_imm;
            skid_type <= dec_type;
            occ       <= 2'd2;
          end else if (pop) begin
            occ <= 2'd0;
          end
        end
        default: if (pop) begin
          head_imm  <= skid_imm;
          head_type <= skid_type;
          occ       <= 2'd1;
        end
      endcase
    end
  end

  // Saturating count of accepted instructions that matched no class
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL)
      unk <= '0;
    else if (push && (dec_type == IT_NONE) && (unk != {CNT_W{1'b1}}))
      unk <= unk + 1'b1;
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe (default DATA_W=64, CNT_W=8).
module tb_imm_extend_pipe;
  logic        Clk = 1'b0;
  logic        ResetL;
  logic        InValid;
  logic        InReady;
  logic [31:0] Instr;
  logic        Ctrl;
  logic        OutValid;
  logic        OutReady;
  logic [63:0] BusImm;
  logic [2:0]  ImmType;
  logic [7:0]  UnkCount;

  int total = 0;
  int bad   = 0;

`ifdef IMM_BRANCH_SHIFT_EN
  localparam int SH = 2;
`else
  localparam int SH = 0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic        ctrl;
    logic [63:0] imm;
    logic [2:0]  typ;
  } vec_t;

  vec_t tbl[15];

  imm_extend_pipe #(.DATA_W(64), .CNT_W(8)) dut (
    .Clk(Clk), .ResetL(ResetL), .InValid(InValid), .InReady(InReady),
    .Instr(Instr), .Ctrl(Ctrl), .OutValid(OutValid), .OutReady(OutReady),
    .BusImm(BusImm), .ImmType(ImmType), .UnkCount(UnkCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] in, input logic c,
                         input logic [63:0] imm, input logic [2:0] t);
    tbl[i].instr = in; tbl[i].ctrl = c; tbl[i].imm = imm; tbl[i].typ = t;
  endtask

  // one accept into an empty pipe; result must show the very next cycle
  task automatic apply(input vec_t v, input int idx);
    @(negedge Clk);
    InValid = 1'b1; Instr = v.instr; Ctrl = v.ctrl; OutReady = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    chk($sformatf("vec%0d valid", idx), {63'b0, OutValid}, 64'd1);
    chk($sformatf("vec%0d imm", idx), BusImm, v.imm);
    chk($sformatf("vec%0d type", idx), {61'b0, ImmType}, {61'b0, v.typ});
    @(posedge Clk); #1;
    chk($sformatf("vec%0d drained", idx), {63'b0, OutValid}, 64'd0);
    chk($sformatf("vec%0d hold", idx), BusImm, v.imm);
  endtask

  initial begin
    set_vec(0,  32'h17FFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF << SH, 3'd1);
    set_vec(1,  32'h17FFFFFF, 1'b1, 64'h0000000003FFFFFF << SH, 3'd1);
    set_vec(2,  32'h94000004, 1'b0, 64'd4 << SH,                3'd1);
    set_vec(3,  32'hB4FFFFE0, 1'b0, 64'hFFFFFFFFFFFFFFFF << SH, 3'd2);
    set_vec(4,  32'hB4FFFFE0, 1'b1, 64'h000000000007FFFF << SH, 3'd2);
    set_vec(5,  32'h54000020, 1'b0, 64'd1 << SH,                3'd2);
    set_vec(6,  32'hF8500000, 1'b0, 64'hFFFFFFFFFFFFFF00,       3'd3);
    set_vec(7,  32'hF8500000, 1'b1, 64'h0000000000000100,       3'd3);
    set_vec(8,  32'h91000C00, 1'b0, 64'h3,                      3'd4);
    set_vec(9,  32'h91200000, 1'b0, 64'hFFFFFFFFFFFFF800,       3'd4);
    set_vec(10, 32'h91200000, 1'b1, 64'h0000000000000800,       3'd4);
    set_vec(11, 32'hD2A24680, 1'b0, 64'h0000000012340000,       3'd5);
    set_vec(12, 32'hF2FFFFE0, 1'b1, 64'hFFFF000000000000,       3'd5);
    set_vec(13, 32'h00000000, 1'b0, 64'h0,                      3'd0);
    set_vec(14, 32'hFFFFFFFF, 1'b0, 64'h0,                      3'd0);

    ResetL = 1'b0; InValid = 1'b0; Instr = '0; Ctrl = 1'b0; OutReady = 1'b0;
    #12;
    chk("rst inready", {63'b0, InReady}, 64'd1);
    chk("rst outvalid", {63'b0, OutValid}, 64'd0);
    chk("rst imm", BusImm, 64'd0);
    chk("rst type", {61'b0, ImmType}, 64'd0);
    chk("rst unk", {56'b0, UnkCount}, 64'd0);
    @(negedge Clk); ResetL = 1'b1;

    for (int i = 0; i < 15; i++) apply(tbl[i], i);
    chk("unk after table", {56'b0, UnkCount}, 64'd2);

    // backpressure: two accepted, third waits, drain preserves order
    @(negedge Clk);
    OutReady = 1'b0; InValid = 1'b1; Instr = 32'h91000C00; Ctrl = 1'b0;
    @(posedge Clk); #1;
    chk("bp inready1", {63'b0, InReady}, 64'd1);
    @(negedge Clk); Instr = 32'hD2A24680;
    @(posedge Clk); #1;
    chk("bp full inready", {63'b0, InReady}, 64'd0);
    chk("bp head a", BusImm, 64'h3);
    @(negedge Clk); Instr = 32'hF8500000;
    @(posedge Clk); #1;
    chk("bp still full", {63'b0, InReady}, 64'd0);
    chk("bp stable imm", BusImm, 64'h3);
    chk("bp stable type", {61'b0, ImmType}, 64'd4);
    @(negedge Clk); OutReady = 1'b1;
    @(posedge Clk); #1;
    chk("bp head b", BusImm, 64'h12340000);
    chk("bp head b type", {61'b0, ImmType}, 64'd5);
    chk("bp inready again", {63'b0, InReady}, 64'd1);
    @(posedge Clk); #1;
    chk("bp head c", BusImm, 64'hFFFFFFFFFFFFFF00);
    chk("bp c valid", {63'b0, OutValid}, 64'd1);
    @(negedge Clk); InValid = 1'b0;
    @(posedge Clk); #1;
    chk("bp empty", {63'b0, OutValid}, 64'd0);

    // saturation of the unknown-opcode counter
    @(negedge Clk); Instr = 32'h0; InValid = 1'b1; OutReady = 1'b1;
    for (int k = 0; k < 300; k++) @(posedge Clk);
    #1;
    chk("sat inready", {63'b0, InReady}, 64'd1);
    @(negedge Clk); InValid = 1'b0;
    @(posedge Clk); #1;
    chk("sat unk", {56'b0, UnkCount}, 64'd255);
    chk("sat imm", BusImm, 64'd0);
    chk("sat type", {61'b0, ImmType}, 64'd0);

    // reset with two entries buffered
    @(negedge Clk); OutReady = 1'b0; InValid = 1'b1; Instr = 32'h91000C00;
    @(negedge Clk); Instr = 32'hD2A24680;
    @(negedge Clk); InValid = 1'b0;
    chk("pre-rst full", {63'b0, InReady}, 64'd0);
    #2 ResetL = 1'b0;
    #1;
    chk("mid rst outvalid", {63'b0, OutValid}, 64'd0);
    chk("mid rst unk", {56'b0, UnkCount}, 64'd0);
    chk("mid rst inready", {63'b0, InReady}, 64'd1);
    chk("mid rst imm", BusImm, 64'd0);
    @(negedge Clk); ResetL = 1'b1; OutReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); #1;
      chk($sformatf("post rst idle%0d", k), {63'b0, OutValid}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
